// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: FSM states, command
// bytes and the register-file addresses that hold the ALU operands.
package sys_ctrl_pkg;

    localparam int FUN_W = 4;

    localparam logic [7:0] CMD_REG_WR     = 8'hAA;
    localparam logic [7:0] CMD_REG_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPS    = 8'hCC;
    localparam logic [7:0] CMD_ALU_NO_OPS = 8'hDD;

    localparam int OP_A_ADDR = 0;
    localparam int OP_B_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        ALU_FUN,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } state_t;

endpackage

// File: rtl/sys_ctrl_if.sv
// Bundle of every datapath/handshake signal between the controller and
// the UART, register file, ALU and TX FIFO. The master modport is the
// controller's view; the slave modport is the surrounding system's view.
interface sys_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int ALU_W  = 16
);

    logic [DATA_W-1:0]             RX_P_DATA;
    logic                          RX_D_VLD;
    logic [DATA_W-1:0]             RdData;
    logic                          RdData_Valid;
    logic [ALU_W-1:0]              ALU_OUT;
    logic                          OUT_VALID;
    logic                          FIFO_FULL;

    logic [ADDR_W-1:0]             Address;
    logic                          WrEn;
    logic                          RdEn;
    logic [DATA_W-1:0]             WrData;
    logic                          ALU_EN;
    logic [sys_ctrl_pkg::FUN_W-1:0] ALU_FUN;
    logic                          CLK_EN;
    logic [DATA_W-1:0]             TX_P_DATA;
    logic                          TX_D_VLD;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid,
        input  ALU_OUT, OUT_VALID, FIFO_FULL,
        output Address, WrEn, RdEn, WrData,
        output ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid,
        output ALU_OUT, OUT_VALID, FIFO_FULL,
        input  Address, WrEn, RdEn, WrData,
        input  ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
    );

endinterface

// File: rtl/sys_ctrl.sv
// System controller: decodes command bytes from the UART receiver, drives
// register-file writes/reads and ALU operations, and streams results to
// the TX FIFO honouring its full flag. Every output is a flop; the strobe
// outputs default low each cycle so they are single-cycle pulses.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int ALU_W  = 16
) (
    input  logic          CLK,
    input  logic          RST,
    sys_ctrl_if.master    bus
);

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wr_data_q,   wr_data_d;
    logic                wr_en_q,     wr_en_d;
    logic                rd_en_q,     rd_en_d;
    logic                alu_en_q,    alu_en_d;
    logic [FUN_W-1:0]    alu_fun_q,   alu_fun_d;
    logic                clk_en_q,    clk_en_d;
    logic [DATA_W-1:0]   tx_data_q,   tx_data_d;
    logic                tx_vld_q,    tx_vld_d;
    logic [ALU_W-1:0]    res_q,       res_d;

    // Next-state and next-output decode; strobes are low unless an event fires them.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        alu_fun_d = alu_fun_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = 1'b0;
        res_d     = res_q;

        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    case (bus.RX_P_DATA)
                        CMD_REG_WR:     state_d = WR_ADDR;
                        CMD_REG_RD:     state_d = RD_ADDR;
                        CMD_ALU_OPS:    state_d = OP_A;
                        CMD_ALU_NO_OPS: state_d = ALU_FUN;
                        default:        state_d = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = bus.RX_P_DATA[ADDR_W-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = bus.RX_P_DATA[ADDR_W-1:0];
                    rd_en_d = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // A read returns one byte; parking it in the upper half lets
                // TX_HI send it without a separate single-byte path.
                if (bus.RdData_Valid) begin
                    res_d   = {bus.RdData, {DATA_W{1'b0}}};
                    state_d = TX_HI;
                end
            end
            OP_A: begin
                if (bus.RX_D_VLD) begin
                    addr_d    = ADDR_W'(OP_A_ADDR);
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = OP_B;
                end
            end
            OP_B: begin
                if (bus.RX_D_VLD) begin
                    addr_d    = ADDR_W'(OP_B_ADDR);
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ALU_FUN;
                end
            end
            ALU_FUN: begin
                if (bus.RX_D_VLD) begin
                    alu_fun_d = bus.RX_P_DATA[FUN_W-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (bus.OUT_VALID) begin
                    res_d   = bus.ALU_OUT;
                    state_d = TX_LO;
                end
            end
            TX_LO: begin
                if (!bus.FIFO_FULL) begin
                    tx_data_d = res_q[DATA_W-1:0];
                    tx_vld_d  = 1'b1;
                    state_d   = TX_HI;
                end
            end
            TX_HI: begin
                if (!bus.FIFO_FULL) begin
                    tx_data_d = res_q[ALU_W-1:DATA_W];
                    tx_vld_d  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The ALU clock runs for every cycle spent in ALU_FUN or ALU_WAIT.
        clk_en_d = (state_d == ALU_FUN) || (state_d == ALU_WAIT);
    end

    // State, result buffer and all registered outputs; cleared asynchronously.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            alu_fun_q <= '0;
            clk_en_q  <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            alu_fun_q <= alu_fun_d;
            clk_en_q  <= clk_en_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            res_q     <= res_d;
        end
    end

    assign bus.Address   = addr_q;
    assign bus.WrEn      = wr_en_q;
    assign bus.RdEn      = rd_en_q;
    assign bus.WrData    = wr_data_q;
    assign bus.ALU_EN    = alu_en_q;
    assign bus.ALU_FUN   = alu_fun_q;
    assign bus.CLK_EN    = clk_en_q;
    assign bus.TX_P_DATA = tx_data_q;
    assign bus.TX_D_VLD  = tx_vld_q;

endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 Parameter DATA_W, 8, UART byte and register-file data width.
REQ-002 Parameter ADDR_W, 4, register-file address width.
REQ-003 Parameter ALU_W, 16, ALU result width; SHALL equal 2*DATA_W.
REQ-004 CLK  in  1  single system clock; all state on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 RX_P_DATA  in  DATA_W  byte from UART RX; RX_D_VLD  in  1  one-cycle strobe per received byte.
REQ-007 RdData  in  DATA_W  register-file read data; RdData_Valid  in  1  read-data strobe.
REQ-008 ALU_OUT  in  ALU_W  ALU result; OUT_VALID  in  1  result strobe.
REQ-009 FIFO_FULL  in  1  TX FIFO full flag.
REQ-010 Address  out  ADDR_W; WrEn  out  1; RdEn  out  1; WrData  out  DATA_W; all go to the register file.
REQ-011 ALU_EN  out  1; ALU_FUN  out  4; CLK_EN  out  1  ALU clock-gate enable.
REQ-012 TX_P_DATA  out  DATA_W; TX_D_VLD  out  1  one-cycle TX FIFO write strobe.

Function
REQ-013 Command bytes: 0xAA reg-write (addr, data); 0xBB reg-read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU without operands (fun).
REQ-014 FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
REQ-015 IDLE: on RX_D_VLD, 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->ALU_FUN; any other byte is discarded and the FSM stays in IDLE.
REQ-016 WR_ADDR: next strobed byte latched, low ADDR_W bits kept as address; ->WR_DATA.
REQ-017 WR_DATA: next strobed byte drives WrEn=1 for exactly one cycle with latched Address and WrData; ->IDLE.
REQ-018 RD_ADDR: next strobed byte drives RdEn=1 for one cycle; ->RD_WAIT.
REQ-019 RD_WAIT: on RdData_Valid, RdData captured to one-byte result buffer; ->TX_HI (single-byte send).
REQ-020 OP_A / OP_B: each strobed byte written with WrEn one cycle to address 0 (A) then 1 (B); ->OP_B, ->ALU_FUN.
REQ-021 ALU_FUN: CLK_EN=1 from entry until ALU_WAIT exit; strobed byte low 4 bits -> ALU_FUN, ALU_EN=1 one cycle; ->ALU_WAIT.
REQ-022 ALU_WAIT: on OUT_VALID, ALU_OUT captured to 16-bit result buffer; ->TX_LO.
REQ-023 TX_LO: when FIFO_FULL=0, TX_P_DATA=result[7:0], TX_D_VLD=1 one cycle; ->TX_HI. TX_HI: same with result[15:8] (or RdData byte); ->IDLE.
REQ-024 FIFO_FULL=1 in TX_LO/TX_HI: TX_D_VLD held 0, state held, buffer unchanged; no byte lost or duplicated.
REQ-025 RX_D_VLD in RD_WAIT, ALU_WAIT, TX_LO, TX_HI: byte dropped, no state change.
REQ-026 Latency: WrEn asserted the cycle after the data strobe; first TX_D_VLD no earlier than the cycle after OUT_VALID/RdData_Valid.
REQ-027 WrEn, RdEn, ALU_EN, TX_D_VLD SHALL be registered and never high in the same cycle.

Reset
REQ-028 RST low, at any time including mid-command: state=IDLE, all outputs 0, buffers 0, asynchronously.
REQ-029 After RST release, first accepted byte is treated as a command byte.

Structure
REQ-030 Shared package sys_ctrl_pkg: state enum, command constants (0xAA/0xBB/0xCC/0xDD), operand addresses 0/1.
REQ-031 Single module, no sub-modules; result buffer and FSM coexist in one file.

Verification
REQ-032 Write: bytes AA,05,3C -> one-cycle WrEn, Address=5, WrData=0x3C; then BB,05 + RdData_Valid(0x3C) -> TX_P_DATA=0x3C, one strobe.
REQ-033 ALU: CC,07,03,00 -> writes 0x07@0, 0x03@1, ALU_FUN=0, ALU_EN pulse; ALU_OUT=0x000A -> TX bytes 0x0A then 0x00.
REQ-034 Backpressure: DD,02, ALU_OUT=0x1234, FIFO_FULL=1 for 5 cycles -> no TX_D_VLD; after release 0x34 then 0x12, exactly two strobes.
REQ-035 Unknown: byte 0x55 in IDLE -> no output activity, next AA,01,FF performs write correctly.
REQ-036 Reset mid-op: RST low after CC,07 -> outputs 0, IDLE; next BB,02 handled as fresh read.
